// File: rtl/pixel_pipe.sv
// Two-stage attribute-to-colour pixel pipeline with a writable
// 16-entry palette and frame-counted blink phase.
module pixel_pipe #(
    parameter int COLOR_BITS   = 3,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pixclk,
    input  logic [7:0]                attcode,
    input  logic                      pixel,
    input  logic                      blank,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blink_en,
    input  logic                      pal_we,
    input  logic [3:0]                pal_addr,
    input  logic [3*COLOR_BITS-1:0]   pal_data,
    output logic [COLOR_BITS-1:0]     r,
    output logic [COLOR_BITS-1:0]     g,
    output logic [COLOR_BITS-1:0]     b,
    output logic                      hsync,
    output logic                      vsync
);

    localparam int PW = 3 * COLOR_BITS;
    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    // MSB carries the colour, middle bits the intensity, LSB both.
    function automatic logic [COLOR_BITS-1:0] comp_dflt(
        input logic c,
        input logic i
    );
        logic [COLOR_BITS-1:0] v;
        v = {COLOR_BITS{i}};
        v[COLOR_BITS-1] = c;
        v[0] = c & i;
        return v;
    endfunction

    function automatic logic [PW-1:0] pal_dflt(input logic [3:0] n);
        return {comp_dflt(n[2], n[3]),
                comp_dflt(n[1], n[3]),
                comp_dflt(n[0], n[3])};
    endfunction

    logic [PW-1:0] pal_q [16];
    logic [PW-1:0] pal_d [16];

    logic [3:0]    s1_idx_q, s1_idx_d;
    logic          s1_blank_q, s1_blank_d;
    logic          s1_hs_q, s1_hs_d;
    logic          s1_vs_q, s1_vs_d;
    logic [PW-1:0] rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          vs_prev_q, vs_prev_d;
    logic [7:0]    frame_q, frame_d;
    logic          phase_q, phase_d;

    logic fg;
    logic frame_evt;

    assign fg        = pixel & ~(blink_en & attcode[7] & phase_q);
    assign frame_evt = vs_prev_q & ~vsync_in;

    // Palette write port, not gated by the pixel enable.
    always_comb begin
        pal_d = pal_q;
        if (pal_we) pal_d[pal_addr] = pal_data;
    end

    // Palette storage; reset reloads the standard 16-colour set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= pal_dflt(4'(i));
        end else begin
            pal_q <= pal_d;
        end
    end

    // Pipeline and blink next-state; everything holds when pixclk=0.
    always_comb begin
        s1_idx_d   = s1_idx_q;
        s1_blank_d = s1_blank_q;
        s1_hs_d    = s1_hs_q;
        s1_vs_d    = s1_vs_q;
        rgb_d      = rgb_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        vs_prev_d  = vs_prev_q;
        frame_d    = frame_q;
        phase_d    = phase_q;
        if (pixclk) begin
            s1_idx_d   = fg ? attcode[3:0]
                            : {~blink_en & attcode[7], attcode[6:4]};
            s1_blank_d = blank;
            s1_hs_d    = hsync_in;
            s1_vs_d    = vsync_in;
            rgb_d      = s1_blank_q ? pal_q[s1_idx_q] : '0;
            hs_d       = s1_hs_q;
            vs_d       = s1_vs_q;
            vs_prev_d  = vsync_in;
            if (frame_evt) begin
                if (frame_q == LAST_FRAME) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 8'd1;
                end
            end
        end
    end

    // Pipeline, sync and blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_idx_q   <= '0;
            s1_blank_q <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            vs_prev_q  <= 1'b1;
            frame_q    <= '0;
            phase_q    <= 1'b0;
        end else begin
            s1_idx_q   <= s1_idx_d;
            s1_blank_q <= s1_blank_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            vs_prev_q  <= vs_prev_d;
            frame_q    <= frame_d;
            phase_q    <= phase_d;
        end
    end

    assign r     = rgb_q[PW-1 -: COLOR_BITS];
    assign g     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign b     = rgb_q[COLOR_BITS-1:0];
    assign hsync = hs_q;
    assign vsync = vs_q;

endmodule

// File: tb/tb_pixel_pipe.sv
// Scoreboard bench for pixel_pipe: a frame-count reference model
// predicts every output cycle; a monitor pops and compares.
module tb_pixel_pipe;

    localparam int CB = 3;
    localparam int BF = 2;

    logic          clk = 0;
    logic          rst_n;
    logic          pixclk;
    logic [7:0]    attcode;
    logic          pixel;
    logic          blank;
    logic          hsync_in;
    logic          vsync_in;
    logic          blink_en;
    logic          pal_we;
    logic [3:0]    pal_addr;
    logic [3*CB-1:0] pal_data;
    logic [CB-1:0] r, g, b;
    logic          hsync, vsync;

    pixel_pipe #(.COLOR_BITS(CB), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .pixclk(pixclk),
        .attcode(attcode), .pixel(pixel), .blank(blank),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .blink_en(blink_en), .pal_we(pal_we),
        .pal_addr(pal_addr), .pal_data(pal_data),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, want, $time);
        end
    endtask

    // Reference palette default from the colour/intensity rule.
    function automatic logic [8:0] ref_dflt(input int n);
        int ii;
        int v;
        logic [8:0] e;
        e  = '0;
        ii = (n >> 3) & 1;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (n >> (2 - k)) & 1;
            v = (c << (CB - 1)) | (ii * ((1 << (CB - 1)) - 2)) | (c & ii);
            e = e | (9'(v) << (CB * (2 - k)));
        end
        return e;
    endfunction

    logic [8:0] mpal [16];
    int         nev;
    logic       vs_prev;
    logic [3:0] p_idx;
    logic       p_blank, p_hs, p_vs;
    exp_t       last;
    logic       mphase, mfg;

    // Reference model: one expected output per clk edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mpal[i] = ref_dflt(i);
            nev     = 0;
            vs_prev = 1'b1;
            p_idx   = 4'd0;
            p_blank = 1'b0;
            p_hs    = 1'b1;
            p_vs    = 1'b1;
            last.rgb = '0;
            last.hs  = 1'b1;
            last.vs  = 1'b1;
        end else begin
            if (pixclk) begin
                last.rgb = p_blank ? mpal[p_idx] : 9'd0;
                last.hs  = p_hs;
                last.vs  = p_vs;
                mphase = ((nev / BF) % 2) == 1;
                mfg = pixel && !(blink_en && attcode[7] && mphase);
                if (mfg) p_idx = attcode[3:0];
                else p_idx = {!blink_en && attcode[7], attcode[6:4]};
                p_blank = blank;
                p_hs    = hsync_in;
                p_vs    = vsync_in;
                if (vs_prev && !vsync_in) nev++;
                vs_prev = vsync_in;
            end
            if (pal_we) mpal[pal_addr] = pal_data;
        end
        exp_q.push_back(last);
        ->chk_ev;
    end

    // Monitor: compare the DUT just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rgb", 32'({r, g, b}), 32'(e.rgb));
                chk("sb_sync", 32'({hsync, vsync}), 32'({e.hs, e.vs}));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vfall();
        vsync_in = 1'b0;
        step(2);
        vsync_in = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n    = 1'b0;
        pixclk   = 1'b1;
        attcode  = 8'h00;
        pixel    = 1'b0;
        blank    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        blink_en = 1'b1;
        pal_we   = 1'b0;
        pal_addr = 4'd0;
        pal_data = '0;
        step(3);
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_sync", 32'({hsync, vsync}), 32'b11);

        rst_n   = 1'b1;
        attcode = 8'h1E;
        pixel   = 1'b1;
        blank   = 1'b1;
        step(2);
        chk("fg_1e", 32'({r, g, b}), 32'b111_111_010);
        pixel = 1'b0;
        step(2);
        chk("bg_1e", 32'({r, g, b}), 32'b000_000_100);
        blank = 1'b0;
        step(2);
        chk("blanked", 32'({r, g, b}), 32'd0);
        hsync_in = 1'b0;
        step(1);
        chk("hs_lat1", 32'(hsync), 32'd1);
        hsync_in = 1'b1;
        vsync_in = 1'b0;
        step(1);
        chk("hs_lat2", 32'(hsync), 32'd0);
        vsync_in = 1'b1;
        step(1);
        chk("vs_lat2", 32'({hsync, vsync}), 32'b10);
        step(1);

        blank   = 1'b1;
        attcode = 8'h8F;
        pixel   = 1'b1;
        step(3);
        chk("blink_on", 32'({r, g, b}), 32'h1FF);
        vfall();
        vfall();
        step(2);
        chk("blink_off", 32'({r, g, b}), 32'd0);
        vfall();
        vfall();
        step(2);
        chk("blink_back", 32'({r, g, b}), 32'h1FF);
        blink_en = 1'b0;
        step(2);
        chk("noblink_fg", 32'({r, g, b}), 32'h1FF);
        pixel = 1'b0;
        step(2);
        chk("bright_bg", 32'({r, g, b}), 32'b010_010_010);

        blink_en = 1'b1;
        pixel    = 1'b1;
        attcode  = 8'h05;
        step(3);
        chk("ent5_dflt", 32'({r, g, b}), 32'b100_000_100);
        pal_we   = 1'b1;
        pal_addr = 4'd5;
        pal_data = 9'h1FF;
        step(1);
        chk("ent5_coll", 32'({r, g, b}), 32'b100_000_100);
        pal_we = 1'b0;
        step(1);
        chk("ent5_new", 32'({r, g, b}), 32'h1FF);
        rst_n    = 1'b0;
        pal_we   = 1'b1;
        pal_data = 9'h000;
        step(2);
        rst_n  = 1'b1;
        pal_we = 1'b0;
        step(2);
        chk("ent5_rstwr", 32'({r, g, b}), 32'b100_000_100);

        for (int blk = 0; blk < 30; blk++) begin
            int pcmode;
            pcmode   = $urandom_range(0, 2);
            blink_en = 1'($urandom_range(0, 1));
            for (int n = 0; n < 80; n++) begin
                if (pcmode == 0) pixclk = 1'b1;
                else if (pcmode == 1) pixclk = (n % 4) == 0;
                else pixclk = 1'($urandom_range(0, 1));
                attcode  = 8'($urandom);
                pixel    = 1'($urandom);
                blank    = $urandom_range(0, 7) != 0;
                hsync_in = $urandom_range(0, 9) != 0;
                vsync_in = $urandom_range(0, 5) != 0;
                pal_we   = $urandom_range(0, 9) == 0;
                pal_addr = 4'($urandom);
                pal_data = 9'($urandom);
                rst_n    = $urandom_range(0, 199) != 0;
                step(1);
            end
        end

        rst_n  = 1'b1;
        pal_we = 1'b0;
        pixclk = 1'b1;
        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_pipe.md
PIXEL_PIPE -- requirements
Module: pixel_pipe

Interface
REQ-001 SHALL provide parameter COLOR_BITS, default 3, meaning bits per colour component (legal range 2..8).
REQ-002 SHALL provide parameter BLINK_FRAMES, default 16, meaning frames per blink half-period (legal range 1..255).
REQ-003 SHALL have port clk  input  1  system clock; all registers clock on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pixclk  input  1  pixel enable; the pixel pipeline and blink logic advance only on clk edges where pixclk=1.
REQ-006 SHALL have port attcode  input  8  attribute: [7] blink/bg-intensity, [6:4] bg RGB, [3] fg intensity, [2:0] fg RGB.
REQ-007 SHALL have port pixel  input  1  glyph pixel, 1 = foreground.
REQ-008 SHALL have port blank  input  1  display enable, 1 = visible.
REQ-009 SHALL have ports hsync_in, vsync_in  input  1 each  raw syncs, active-low.
REQ-010 SHALL have port blink_en  input  1  mode: 1 = attcode[7] is blink, 0 = attcode[7] is bg intensity (16 bg colours).
REQ-011 SHALL have ports pal_we (1), pal_addr (4), pal_data (3*COLOR_BITS, packed {R,G,B})  inputs  palette write port.
REQ-012 SHALL have ports r, g, b  output  COLOR_BITS each  registered colour.
REQ-013 SHALL have ports hsync, vsync  output  1 each  registered syncs.

Function
REQ-014 SHALL hold a 16-entry palette of 3*COLOR_BITS-bit entries.
REQ-015 SHALL write pal_data to entry pal_addr on every clk edge with pal_we=1, independent of pixclk.
REQ-016 Stage 1 (pixclk=1): fg = pixel & ~(blink_en & attcode[7] & blink_phase); idx = fg ? attcode[3:0] : {~blink_en & attcode[7], attcode[6:4]}; register idx, blank, hsync_in, vsync_in.
REQ-017 Stage 2 (pixclk=1): {r,g,b} <= stage-1 blank ? palette[stage-1 idx] : 0; hsync/vsync <= stage-1 copies.
REQ-018 Latency SHALL be exactly 2 pixclk-qualified cycles, identical for colour and syncs; with pixclk=0 all pipeline registers and outputs hold.
REQ-019 A palette write and stage-2 read of the same entry on the same edge SHALL output the old entry; the new value is visible from the next read.
REQ-020 Frame event = vsync_in sampled 1 on previous pixclk cycle and 0 on current pixclk cycle (falling edge); detection only on pixclk=1 edges.
REQ-021 Frame counter (8 bit) SHALL increment on each frame event; on reaching BLINK_FRAMES-1 with an event it SHALL wrap to 0 and toggle blink_phase.
REQ-022 blink_en=0 SHALL not stop the frame counter or blink_phase; it only disables their effect.
REQ-023 blank=0 SHALL force r=g=b=0 regardless of palette content.

Reset
REQ-024 rst_n=0 SHALL immediately force r=g=b=0, hsync=vsync=1, stage-1 registers to idx=0/blank=0/syncs=1, frame counter=0, blink_phase=0, vsync edge history=1.
REQ-025 Reset SHALL load palette entry i with component c (c = i[2] red, i[1] green, i[0] blue, I = i[3]): MSB=c, LSB=c&I, all middle bits=I.
REQ-026 Reset mid-frame SHALL discard in-flight pixels; first valid output is the second pixclk cycle after release.
REQ-027 Palette writes with rst_n=0 SHALL be ignored.

Verification
REQ-028 Reset, COLOR_BITS=3, blink_en=1, attcode=0x1E, pixel=1, blank=1, pixclk=1 every cycle -> after 2 cycles r=3'b111, g=3'b111, b=3'b010.
REQ-029 Same stimulus, pixel=0 -> b=3'b100, r=g=3'b000; blank=0 -> all 0 two cycles later; hsync_in/vsync_in pulses appear on outputs delayed exactly 2 cycles.
REQ-030 BLINK_FRAMES=2, blink_en=1, attcode=0x8F, pixel=1: drive 2 vsync falling edges -> outputs switch from entry 15 to entry 0 (bg black); 2 more -> back to entry 15; blink_en=0 -> entry 15 steady, pixel=0 selects entry 8.
REQ-031 pixclk asserted every 4th clk -> outputs change only on those edges, latency 2 enabled cycles, syncs still aligned.
REQ-032 Write entry 5 = 0x1FF while it is being displayed -> old value on collision edge, 9'h1FF (r=g=b=3'b111) next enabled cycle; write with rst_n=0 -> entry 5 unchanged at reset default.
